// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage
//   Two-stage issue/resolve wrapper around a combinational ALU. It decodes a
//   MIPS instruction into ALU controls and then captures the ALU result.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic        flush,

    output logic [2:0]  ALUOP,
    output logic [31:0] In1,
    output logic [31:0] In2,
    input  logic [31:0] OUT,
    input  logic        ZeroFlag,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_wr,
    output logic        res_mem_rd,
    output logic        res_mem_wr,
    output logic [31:0] res_store_data,
    output logic        res_br_taken,
    output logic [31:0] res_br_target,
    output logic        res_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLL  = 3'd4;
    localparam logic [2:0] ALU_SRL  = 3'd5;
    localparam logic [2:0] ALU_CMP  = 3'd6;
    localparam logic [2:0] ALU_SLT  = 3'd7;

    // Instruction fields
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic        unused_rs_field;

    assign op              = in_instr[31:26];
    assign funct           = in_instr[5:0];
    assign rt_field        = in_instr[20:16];
    assign rd_field        = in_instr[15:11];
    assign shamt           = in_instr[10:6];
    assign imm             = in_instr[15:0];
    assign imm_sext        = {{16{imm[15]}}, imm};
    assign imm_zext        = {16'd0, imm};
    assign unused_rs_field = ^in_instr[25:21];

    // Decode results
    logic [2:0]  dec_aluop;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic [4:0]  dec_dest;
    logic        dec_writes;
    logic        dec_wr;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic [31:0] dec_store;
    logic        dec_beq;
    logic        dec_bne;
    logic [31:0] dec_target;
    logic        dec_illegal;

    always_comb begin
        dec_aluop   = ALU_ADD;
        dec_in1     = 32'd0;
        dec_in2     = 32'd0;
        dec_dest    = 5'd0;
        dec_writes  = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_store   = 32'd0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;

        case (op)
            OP_RTYPE: begin
                dec_dest   = rd_field;
                dec_writes = 1'b1;
                dec_in1    = in_rs_val;
                dec_in2    = in_rt_val;
                case (funct)
                    FN_ADD: dec_aluop = ALU_ADD;
                    FN_SUB: dec_aluop = ALU_SUB;
                    FN_AND: dec_aluop = ALU_AND;
                    FN_OR:  dec_aluop = ALU_OR;
                    FN_SLT: dec_aluop = ALU_SLT;
                    FN_SLL: begin
                        dec_aluop = ALU_SLL;
                        dec_in1   = in_rt_val;
                        dec_in2   = {27'd0, shamt};
                    end
                    FN_SRL: begin
                        dec_aluop = ALU_SRL;
                        dec_in1   = in_rt_val;
                        dec_in2   = {27'd0, shamt};
                    end
                    default: begin
                        dec_illegal = 1'b1;
                        dec_dest    = 5'd0;
                        dec_writes  = 1'b0;
                        dec_in1     = 32'd0;
                        dec_in2     = 32'd0;
                    end
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec_aluop  = ALU_ADD;
                dec_in1    = in_rs_val;
                dec_in2    = imm_sext;
                dec_dest   = rt_field;
                dec_writes = (op != OP_SW);
                dec_mem_rd = (op == OP_LW);
                dec_mem_wr = (op == OP_SW);
                dec_store  = (op == OP_SW) ? in_rt_val : 32'd0;
            end
            OP_ANDI, OP_ORI: begin
                dec_aluop  = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                dec_in1    = in_rs_val;
                dec_in2    = imm_zext;
                dec_dest   = rt_field;
                dec_writes = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec_aluop = ALU_CMP;
                dec_in1   = in_rs_val;
                dec_in2   = in_rt_val;
                dec_beq   = (op == OP_BEQ);
                dec_bne   = (op == OP_BNE);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Writes to r0 are architecturally discarded, so drop the strobe here.
    assign dec_wr     = dec_writes & ~dec_illegal & (dec_dest != 5'd0);
    assign dec_target = (dec_beq | dec_bne)
                      ? (in_pc + 32'd4 + {imm_sext[29:0], 2'b00})
                      : 32'd0;

    // Handshake
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_adv & ~flush;
    assign in_ready = (~s1_valid | s2_adv) & ~flush;
    assign accept   = in_valid & in_ready;

    // S1: execute register. Payload only loads on accept so the ALU inputs
    // stay frozen while the stage is stalled.
    logic [4:0]  s1_rd;
    logic        s1_wr;
    logic        s1_mem_rd;
    logic        s1_mem_wr;
    logic [31:0] s1_store;
    logic        s1_beq;
    logic        s1_bne;
    logic [31:0] s1_target;
    logic        s1_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            ALUOP      <= 3'd0;
            In1        <= 32'd0;
            In2        <= 32'd0;
            s1_rd      <= 5'd0;
            s1_wr      <= 1'b0;
            s1_mem_rd  <= 1'b0;
            s1_mem_wr  <= 1'b0;
            s1_store   <= 32'd0;
            s1_beq     <= 1'b0;
            s1_bne     <= 1'b0;
            s1_target  <= 32'd0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            ALUOP      <= dec_aluop;
            In1        <= dec_in1;
            In2        <= dec_in2;
            s1_rd      <= dec_dest;
            s1_wr      <= dec_wr;
            s1_mem_rd  <= dec_mem_rd;
            s1_mem_wr  <= dec_mem_wr;
            s1_store   <= dec_store;
            s1_beq     <= dec_beq;
            s1_bne     <= dec_bne;
            s1_target  <= dec_target;
            s1_illegal <= dec_illegal;
        end else if (flush || s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // S2: result register, sampling the ALU while S1 hands over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            res_data       <= 32'd0;
            res_rd         <= 5'd0;
            res_wr         <= 1'b0;
            res_mem_rd     <= 1'b0;
            res_mem_wr     <= 1'b0;
            res_store_data <= 32'd0;
            res_br_taken   <= 1'b0;
            res_br_target  <= 32'd0;
            res_illegal    <= 1'b0;
        end else if (s1_adv) begin
            out_valid      <= 1'b1;
            res_data       <= OUT;
            res_rd         <= s1_rd;
            res_wr         <= s1_wr;
            res_mem_rd     <= s1_mem_rd;
            res_mem_wr     <= s1_mem_wr;
            res_store_data <= s1_store;
            res_br_taken   <= (s1_beq & ZeroFlag) | (s1_bne & ~ZeroFlag);
            res_br_target  <= s1_target;
            res_illegal    <= s1_illegal;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the loop.
`default_nettype none

module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        flush;
    logic [2:0]  ALUOP;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [31:0] OUT;
    logic        ZeroFlag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_wr;
    logic        res_mem_rd;
    logic        res_mem_wr;
    logic [31:0] res_store_data;
    logic        res_br_taken;
    logic [31:0] res_br_target;
    logic        res_illegal;

    int vectors = 0;
    int errors  = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .flush(flush),
        .ALUOP(ALUOP), .In1(In1), .In2(In2), .OUT(OUT), .ZeroFlag(ZeroFlag),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_data(res_data), .res_rd(res_rd), .res_wr(res_wr),
        .res_mem_rd(res_mem_rd), .res_mem_wr(res_mem_wr),
        .res_store_data(res_store_data), .res_br_taken(res_br_taken),
        .res_br_target(res_br_target), .res_illegal(res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        case (ALUOP)
            3'd0:    OUT = In1 + In2;
            3'd1:    OUT = In1 - In2;
            3'd2:    OUT = In1 & In2;
            3'd3:    OUT = In1 | In2;
            3'd4:    OUT = In1 << In2[4:0];
            3'd5:    OUT = In1 >> In2[4:0];
            3'd6:    OUT = In1 - In2;
            default: OUT = ($signed(In1) < $signed(In2)) ? 32'd1 : 32'd0;
        endcase
        ZeroFlag = (In1 == In2);
    end

    function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, 5'd1, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd1, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for one edge; returns in cycle N+1.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        in_rs_val = rs;
        in_rt_val = rt;
        tick();
        in_valid  = 1'b0;
    endtask

    logic [31:0] stream_res [4];
    int sent;
    int got;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        in_rs_val = 32'd0; in_rt_val = 32'd0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_aluop", ALUOP, 0);
        chk("rst_in1", In1, 0);
        chk("rst_in2", In2, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_wr", res_wr, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // ADD rd=3: 5 + 2
        send(rtype(5'd2, 5'd3, 5'd0, 6'h20), 32'h0, 32'd5, 32'd2);
        chk("add_aluop", ALUOP, 0);
        chk("add_in1", In1, 5);
        chk("add_in2", In2, 2);
        chk("add_early_valid", out_valid, 0);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_data", res_data, 7);
        chk("add_wr", res_wr, 1);
        chk("add_rd", res_rd, 3);
        tick();
        chk("add_drained", out_valid, 0);

        // SLL rd=4, shamt 4, rt=3
        send(rtype(5'd2, 5'd4, 5'd4, 6'h00), 32'h0, 32'd99, 32'd3);
        chk("sll_aluop", ALUOP, 4);
        chk("sll_in1", In1, 3);
        chk("sll_in2", In2, 4);
        tick();
        chk("sll_data", res_data, 48);
        chk("sll_rd", res_rd, 4);
        tick();

        // ADDI rt=5, imm -1, rs=1
        send(itype(6'h08, 5'd5, 16'hFFFF), 32'h0, 32'd1, 32'd0);
        chk("addi_in2", In2, 32'hFFFF_FFFF);
        tick();
        chk("addi_data", res_data, 0);
        chk("addi_wr", res_wr, 1);
        chk("addi_rd", res_rd, 5);
        tick();

        // ADDI to r0: write suppressed
        send(itype(6'h08, 5'd0, 16'h0001), 32'h0, 32'd1, 32'd0);
        tick();
        chk("addi_r0_wr", res_wr, 0);
        tick();

        // ORI zero-extends
        send(itype(6'h0D, 5'd11, 16'h8001), 32'h0, 32'h10, 32'd0);
        chk("ori_aluop", ALUOP, 3);
        chk("ori_in2", In2, 32'h0000_8001);
        tick();
        chk("ori_data", res_data, 32'h0000_8011);
        tick();

        // SLT signed: -1 < 1
        send(rtype(5'd2, 5'd12, 5'd0, 6'h2A), 32'h0, 32'hFFFF_FFFF, 32'd1);
        chk("slt_aluop", ALUOP, 7);
        tick();
        chk("slt_data", res_data, 1);
        tick();

        // SW and LW
        send(itype(6'h2B, 5'd9, 16'h0008), 32'h0, 32'h1000, 32'hDEAD_BEEF);
        tick();
        chk("sw_addr", res_data, 32'h1008);
        chk("sw_mem_wr", res_mem_wr, 1);
        chk("sw_mem_rd", res_mem_rd, 0);
        chk("sw_store", res_store_data, 32'hDEAD_BEEF);
        chk("sw_wr", res_wr, 0);
        tick();
        send(itype(6'h23, 5'd10, 16'hFFFC), 32'h0, 32'h1000, 32'd0);
        tick();
        chk("lw_addr", res_data, 32'h0FFC);
        chk("lw_mem_rd", res_mem_rd, 1);
        chk("lw_wr", res_wr, 1);
        chk("lw_rd", res_rd, 10);
        tick();

        // BEQ / BNE with equal operands, pc 0x100, imm 3
        send(itype(6'h04, 5'd2, 16'd3), 32'h100, 32'd22, 32'd22);
        chk("beq_aluop", ALUOP, 6);
        tick();
        chk("beq_taken", res_br_taken, 1);
        chk("beq_target", res_br_target, 32'h110);
        chk("beq_wr", res_wr, 0);
        tick();
        send(itype(6'h05, 5'd2, 16'd3), 32'h100, 32'd22, 32'd22);
        tick();
        chk("bne_taken", res_br_taken, 0);
        tick();

        // Stream of four ADDIs with out_ready low in cycles 2..4
        stream_res[0] = 32'd11; stream_res[1] = 32'd21;
        stream_res[2] = 32'd31; stream_res[3] = 32'd41;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                in_instr  = itype(6'h08, 5'(sent + 1), 16'd1);
                in_rs_val = 32'(10 * (sent + 1));
            end
            #1;
            chk($sformatf("stream_in_ready_c%0d", c), in_ready, !(c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) begin
                chk($sformatf("stream_stall_in1_c%0d", c), In1, 20);
                chk($sformatf("stream_stall_data_c%0d", c), res_data, 11);
            end
            if (out_valid && out_ready) begin
                if (got < 4) begin
                    chk($sformatf("stream_res%0d", got), res_data, stream_res[got]);
                    chk($sformatf("stream_rd%0d", got), res_rd, 32'(got + 1));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", sent, 4);
        chk("stream_retired", got, 4);
        chk("stream_idle", out_valid, 0);

        // Flush: P reaches S2, Q sits in S1, R offered during flush
        send(itype(6'h08, 5'd7, 16'd0), 32'h0, 32'd7, 32'd0);
        send(itype(6'h08, 5'd8, 16'd0), 32'h0, 32'd8, 32'd0);
        in_valid = 1'b1;
        in_instr = itype(6'h08, 5'd9, 16'd0);
        in_rs_val = 32'd9;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_s2_valid", out_valid, 1);
        chk("flush_s2_data", res_data, 7);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_no_adv", out_valid, 0);
        tick();
        chk("flush_killed", out_valid, 0);
        chk("flush_not_accepted", In1, 8);
        tick();

        // Illegal opcode, then reset with work in flight
        send({6'h3F, 26'd0}, 32'h0, 32'd5, 32'd6);
        chk("ill_aluop", ALUOP, 0);
        chk("ill_in1", In1, 0);
        chk("ill_in2", In2, 0);
        tick();
        chk("ill_flag", res_illegal, 1);
        chk("ill_wr", res_wr, 0);
        chk("ill_valid", out_valid, 1);
        out_ready = 1'b0;
        send(itype(6'h08, 5'd3, 16'd4), 32'h0, 32'd1, 32'd0);
        chk("pre_rst_in1", In1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_aluop", ALUOP, 0);
        chk("mid_rst_in1", In1, 0);
        chk("mid_rst_in2", In2, 0);
        chk("mid_rst_illegal", res_illegal, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_target", res_br_target, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipelined issue and resolve stage that drives the combinational ALU and consumes its results. Decodes one MIPS instruction per cycle into ALUOP and operand selection, presents `ALUOP`/`In1`/`In2` to the ALU from an execute register, then captures `OUT`/`ZeroFlag` into a result register with branch resolution and write-back control. It sits between the register-file read stage and the memory/write-back stage, with a valid/ready handshake on both sides.

## Interface
- No parameters; datapath fixed at 32 bits, ALUOP fixed at 3 bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction PC.
- `in_rs_val`, `in_rt_val`  in  32 each  register operands.
- `flush`  in  1  kill the instruction in the execute register.
- `ALUOP`  out  3  to ALU; registered.
- `In1`, `In2`  out  32 each  to ALU; registered.
- `OUT`  in  32  ALU result.
- `ZeroFlag`  in  1  ALU equality flag (`In1 == In2`).
- `out_valid`  out  1  result register valid.
- `out_ready`  in  1  downstream accepts the result.
- `res_data`  out  32  ALU result (write-back value or memory address).
- `res_rd`  out  5  destination register.
- `res_wr`  out  1  register write enable.
- `res_mem_rd`, `res_mem_wr`  out  1 each  load/store strobe.
- `res_store_data`  out  32  rt value for SW.
- `res_br_taken`  out  1  branch resolved taken.
- `res_br_target`  out  32  branch target.
- `res_illegal`  out  1  unsupported encoding.

## Operation
- Decode (op = instr[31:26], funct = [5:0]), giving ALUOP, In1, In2 and dest:
  - R-type (op 0): funct 0x20 ADD→0 (rs, rt); 0x22 SUB→1; 0x24 AND→2; 0x25 OR→3; 0x2A SLT→7; dest rd.
  - SLL (funct 0x00)→4 and SRL (funct 0x02)→5: In1 = rt, In2 = zero-extended shamt [10:6]; dest rd.
  - ADDI 0x08, LW 0x23, SW 0x2B→0: In1 = rs, In2 = sign-extended imm[15:0]; dest rt.
  - ANDI 0x0C→2 and ORI 0x0D→3: In2 = zero-extended imm; dest rt.
  - BEQ 0x04 and BNE 0x05→6: In1 = rs, In2 = rt.
  - Any other op/funct: ALUOP 0, operands 0, illegal = 1.
- Write enable `res_wr`: R-type, ADDI, ANDI, ORI, LW; suppressed when illegal or when dest = 0.
- `res_mem_rd` = LW; `res_mem_wr` = SW; `res_store_data` = rt value captured at issue.
- Branch resolution in the result stage:
  - `res_br_taken` = (BEQ & ZeroFlag) | (BNE & ~ZeroFlag).
  - `res_br_target` = pc + 4 + (sext(imm) << 2), modulo 2^32.
  - For non-branches, `res_br_taken` = 0 and `res_br_target` = 0.
- Pipeline stages:
  - S1 (execute register) holds ALUOP/In1/In2 plus metadata and a valid bit.
  - S2 (result register) holds the res_* fields and `out_valid`.
- Advance rules:
  - `s2_adv` = !out_valid | out_ready.
  - `s1_adv` = s1_valid & s2_adv.
  - `in_ready` = (!s1_valid | s2_adv) & !flush.
- S2 captures OUT/ZeroFlag only on `s1_adv`.
- `flush`: clears s1_valid at the next edge and blocks acceptance that cycle. It does not affect S2, and S1 does not advance into S2 in a flush cycle.
- While stalled, S1 holds ALUOP/In1/In2 stable, so the ALU output stays stable.

## Timing
- Reset (async assert, sync release):
  - s1_valid = 0 and `out_valid` = 0.
  - ALUOP = 0, In1 = 0, In2 = 0.
  - All res_* outputs = 0; `in_ready` = 1 after reset.
- Latency: instruction accepted at edge N; ALU inputs valid during cycle N+1; result registered at edge N+1; `out_valid` = 1 in cycle N+2.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Back-pressure: `out_valid` with `out_ready` = 0 holds S2; S1 fills and then `in_ready` drops the same cycle. Accept and retire in the same cycle are allowed.
- Reset asserted mid-operation drops all in-flight instructions immediately.

## Test plan
- ADD, rs = 5, rt = 2 -> ALUOP = 0, In1 = 5, In2 = 2 one cycle after accept; two cycles after accept: res_data = 7, res_wr = 1, res_rd = rd.
- SLL with shamt 4, rt = 3 -> In1 = 3, In2 = 4, res_data = 48; ADDI with imm 0xFFFF, rs = 1 -> In2 = 0xFFFFFFFF, res_data = 0.
- BEQ with rs = rt = 22, pc = 0x100, imm = 3 -> res_br_taken = 1, target 0x110. BNE with the same operands -> not taken.
- Back-to-back stream of 4 instructions with out_ready low for 3 cycles mid-stream -> no loss or duplication; in_ready low only while S1 and S2 are both full; ALU inputs stable during the stall.
- flush asserted with S1 valid and in_valid high -> the S1 instruction never appears at the output; the incoming instruction is not accepted that cycle; the S2 result is unaffected.
- Illegal op 0x3F, then rst_n pulsed low mid-stream -> res_illegal = 1 with res_wr = 0; after reset all outputs = 0 and out_valid = 0.
